// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: FSM encoding, default
// operand width and the iteration-counter width helper.
package mult_pkg;

  localparam int DEF_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int cw(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Start/done handshake and operand/product bus of the shift-add multiplier.
interface shift_add_multiplier_if #(
  parameter int WIDTH = mult_pkg::DEF_WIDTH
);

  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );

endinterface

// File: rtl/shift_add_multiplier_full_adder.sv
// WIDTH-bit ripple-carry adder built from WIDTH chained full-adder cells.
module full_adder #(
  parameter int WIDTH = mult_pkg::DEF_WIDTH
) (
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in
);

  logic [WIDTH:0] carry_s;

  assign carry_s[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign sum[i]       = a[i] ^ b[i] ^ carry_s[i];
    assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
  end

  assign c_out = carry_s[WIDTH];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one shared ripple add per clock over WIDTH
// iterations, 2*WIDTH-bit product with a start/done handshake.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic                   clk,
  input logic                   rst_n,
  shift_add_multiplier_if.slave bus
);

  localparam int CW = cw(WIDTH);

  state_t             state_r;
  state_t             state_nx_s;
  logic [WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]   acc_hi_r;
  logic [WIDTH-1:0]   acc_lo_r;
  logic [CW-1:0]      count_r;
  logic [2*WIDTH-1:0] product_r;
  logic               busy_r;
  logic               done_r;

  logic               load_s;
  logic               step_s;
  logic               finish_s;
  logic [WIDTH-1:0]   addend_s;
  logic [WIDTH-1:0]   sum_s;
  logic               c_out_s;
  logic [2*WIDTH-1:0] shifted_s;

  assign addend_s  = acc_lo_r[0] ? mcand_r : {WIDTH{1'b0}};
  // Carry-out is kept: it lands in the top product bit after the shift.
  assign shifted_s = {c_out_s, sum_s, acc_lo_r[WIDTH-1:1]};

  full_adder #(
    .WIDTH(WIDTH)
  ) u_adder (
    .sum  (sum_s),
    .c_out(c_out_s),
    .a    (acc_hi_r),
    .b    (addend_s),
    .c_in (1'b0)
  );

  // Next-state and datapath control decode.
  always_comb begin
    state_nx_s = state_r;
    load_s     = 1'b0;
    step_s     = 1'b0;
    finish_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          load_s     = 1'b1;
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (count_r == CW'(1)) begin
          finish_s   = 1'b1;
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      DONE: begin
        if (bus.start) begin
          load_s     = 1'b1;
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State register plus registered busy/done derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s == RUN);
      done_r  <= (state_nx_s == DONE);
    end
  end

  // Operand capture, shift-add iteration, counter and product register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r   <= {WIDTH{1'b0}};
      acc_hi_r  <= {WIDTH{1'b0}};
      acc_lo_r  <= {WIDTH{1'b0}};
      count_r   <= {CW{1'b0}};
      product_r <= {(2*WIDTH){1'b0}};
    end else if (load_s) begin
      mcand_r  <= bus.a;
      acc_hi_r <= {WIDTH{1'b0}};
      acc_lo_r <= bus.b;
      count_r  <= CW'(WIDTH);
    end else if (step_s) begin
      {acc_hi_r, acc_lo_r} <= shifted_s;
      count_r              <= count_r - CW'(1);
      if (finish_s) begin
        product_r <= shifted_s;
      end else begin
        product_r <= product_r;
      end
    end else begin
      count_r <= count_r;
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.product = product_r;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed and random checks of the shift-add multiplier against plain a*b.
module tb_shift_add_multiplier;

  localparam int W = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  shift_add_multiplier_if #(.WIDTH(W)) bus ();

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_op(input int unsigned x, input int unsigned y, output int e0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = W'(x);
    bus.b     = W'(y);
    @(posedge clk);
    #1;
    e0        = cyc;
    bus.start = 1'b0;
  endtask

  // Waits (bounded) for done, then checks latency, product, busy count,
  // busy/done exclusion and that the old product held until done.
  task automatic wait_check(input string tag, input int unsigned exp, input int e0,
                            input bit check_fall);
    logic [2*W-1:0] held;
    int             busy_n;
    int             busy_exp;
    bit             held_ok;
    bit             excl_ok;
    held     = bus.product;
    busy_n   = 0;
    busy_exp = W - (cyc - e0);
    held_ok  = 1'b1;
    excl_ok  = 1'b1;
    while (!bus.done && (cyc - e0) < 20) begin
      if (bus.busy) busy_n++;
      @(posedge clk);
      #1;
      if (!bus.done && bus.product !== held) held_ok = 1'b0;
      if (bus.done && bus.busy) excl_ok = 1'b0;
    end
    chk({tag, " latency"}, 32'(cyc - e0), 32'(W));
    chk({tag, " product"}, 32'(bus.product), 32'(exp));
    chk({tag, " busy_cycles"}, 32'(busy_n), 32'(busy_exp));
    chk({tag, " busy_in_done"}, 32'(bus.busy), 32'd0);
    chk({tag, " held"}, 32'(held_ok), 32'd1);
    chk({tag, " excl"}, 32'(excl_ok), 32'd1);
    if (check_fall) begin
      @(posedge clk);
      #1;
      chk({tag, " done_fall"}, 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    int e0;
    int d1;
    int extra;
    int unsigned x;
    int unsigned y;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset product", 32'(bus.product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    start_op(31, 31, e0);
    wait_check("max", 961, e0, 1'b1);

    start_op(0, 27, e0);
    wait_check("zero_a", 0, e0, 1'b1);
    start_op(19, 0, e0);
    wait_check("zero_b", 0, e0, 1'b1);

    start_op(1, 17, e0);
    wait_check("one_a", 17, e0, 1'b1);
    start_op(31, 1, e0);
    wait_check("one_b", 31, e0, 1'b1);

    // Start pulse while busy must be ignored.
    start_op(6, 7, e0);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = W'(3);
    bus.b     = W'(3);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_check("ignore", 42, e0, 1'b1);
    extra = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.done) extra++;
    end
    chk("ignore single_done", 32'(extra), 32'd0);

    // Reset in the third RUN cycle aborts with no done.
    start_op(5, 5, e0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort done", 32'(bus.done), 32'd0);
    chk("abort product", 32'(bus.product), 32'd0);
    extra = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.done) extra++;
    end
    chk("abort no_done", 32'(extra), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(2, 9, e0);
    wait_check("after_abort", 18, e0, 1'b1);

    // Back-to-back: start held through the done cycle.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = W'(4);
    bus.b     = W'(5);
    @(posedge clk);
    #1;
    e0 = cyc;
    wait_check("b2b first", 20, e0, 1'b0);
    d1    = cyc;
    bus.a = W'(7);
    bus.b = W'(9);
    @(posedge clk);
    #1;
    e0        = cyc;
    bus.start = 1'b0;
    wait_check("b2b second", 63, e0, 1'b1);
    chk("b2b spacing", 32'(e0 + W - d1), 32'(W + 1));

    for (int i = 0; i < 8; i++) begin
      x = $urandom_range(0, 31);
      y = $urandom_range(0, 31);
      start_op(x, y, e0);
      wait_check($sformatf("rand%0d %0dx%0d", i, x, y), x * y, e0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
